// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multicycle RV32I control FSM. It sequences fetch/decode/execute/writeback
//   over a single shared memory port that uses a req/ready handshake. It drives
//   the datapath mux selects and strobes, decodes ALU operations, resolves
//   beq/bne/blt/bge, counts retired instructions, and traps on illegal opcodes
//   or on a memory timeout.
//
// Parameters
//   TIMEOUT      max stalled cycles before a timeout fault (0 disables the watchdog)
//   CNT_W        width of the InstRet counter
//   SUPPORT_JAL  1 = jal is legal, 0 = jal traps as an illegal opcode
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   op, funct3, funct7    instruction fields from the instruction register
//   Zero, Sign            ALU flags used to resolve branches
//   MemReady              memory accepted or completed the current access
//   MemReq, MemWrite      memory request; MemWrite marks the request as a write
//   AdrSrc                memory address select (0 PC, 1 ALUOut)
//   IRWrite, PCWrite      instruction/OldPC load strobe, PC load strobe
//   RegWrite              register file write strobe
//   ALUSrcA/B, ResultSrc  datapath mux selects
//   ImmSrc                immediate format select
//   ALUControl            ALU operation
//   InstRet               retired-instruction count (wraps)
//   Fault, FaultCode      sticky trap flag and the first trap cause
module multicycle_control_unit #(
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 32,
    parameter int SUPPORT_JAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7,
    input  logic             Zero,
    input  logic             Sign,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic [CNT_W-1:0] InstRet,
    output logic             Fault,
    output logic [1:0]       FaultCode
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Wait-counter width. The counter never runs past TIMEOUT-1: once it
    // reaches that value, the next stalled cycle raises the fault.
    localparam int             WCW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] TLIM = WCW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_FAULT
    } state_t;

    state_t         state, state_n;
    logic [1:0]     fault_code_n;
    logic [WCW-1:0] wcnt;
    logic           in_mem, mem_wait, timeout_hit, retire, taken, enter_mem;
    logic [2:0]     alu_dec;

    assign in_mem   = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign mem_wait = in_mem && !MemReady;
    // A MemReady that arrives on the last allowed cycle completes the access,
    // because mem_wait is then low.
    assign timeout_hit = (TIMEOUT != 0) && mem_wait && (wcnt == TLIM);

    assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                    ((state == S_MEMWRITE) && MemReady);

    assign enter_mem = (state_n != state) &&
                       ((state_n == S_FETCH) || (state_n == S_MEMREAD) || (state_n == S_MEMWRITE));

    always_comb begin
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = Sign;
            3'b101:  taken = !Sign;
            default: taken = 1'b0;
        endcase
    end

    // op[5] separates R-type from I-type, so addi with instr[30] set still adds.
    always_comb begin
        case (funct3)
            3'b000:  alu_dec = (op[5] && funct7) ? 3'b001 : 3'b000;
            3'b010:  alu_dec = 3'b101;
            3'b110:  alu_dec = 3'b011;
            3'b111:  alu_dec = 3'b010;
            default: alu_dec = 3'b000;
        endcase
    end

    always_comb begin
        state_n      = state;
        fault_code_n = 2'b00;
        MemReq       = 1'b0;
        MemWrite     = 1'b0;
        AdrSrc       = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        ImmSrc       = 2'b00;
        ALUControl   = 3'b000;
        case (state)
            S_IDLE: state_n = S_FETCH;
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) state_n = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
                case (op)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_R:              state_n = S_EXECR;
                    OP_I:              state_n = S_EXECI;
                    OP_BR:             state_n = S_BRANCH;
                    OP_JAL: begin
                        if (SUPPORT_JAL != 0) begin
                            state_n = S_JAL;
                        end else begin
                            state_n      = S_FAULT;
                            fault_code_n = 2'b01;
                        end
                    end
                    default: begin
                        state_n      = S_FAULT;
                        fault_code_n = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? 2'b01 : 2'b00;
                state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_n   = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (MemReady) state_n = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec;
                state_n    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                state_n    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_n  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                PCWrite    = taken;
                state_n    = S_FETCH;
            end
            S_JAL: begin
                // PC <- branch target held in ALUOut; ALU forms rd = OldPC + 4.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ImmSrc  = 2'b11;
                PCWrite = 1'b1;
                state_n = S_ALUWB;
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_n      = S_FAULT;
            fault_code_n = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            InstRet   <= '0;
            Fault     <= 1'b0;
            FaultCode <= 2'b00;
        end else begin
            state <= state_n;
            if (enter_mem)
                wcnt <= '0;
            else if (timeout_hit == 1'b0 && mem_wait && (TIMEOUT != 0) && (wcnt != TLIM))
                wcnt <= wcnt + WCW'(1);
            if (retire)
                InstRet <= InstRet + CNT_W'(1);
            // FAULT is left only through reset, so the first cause stays latched.
            if ((state_n == S_FAULT) && (state != S_FAULT)) begin
                Fault     <= 1'b1;
                FaultCode <= fault_code_n;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. It builds expected per-cycle output
// records from instruction-level rules, checks the DUT against them on every
// cycle, and adds literal checks on key scenarios.
module tb_multicycle_control_unit;

    localparam int TO = 4;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RR  = 7'b0110011;
    localparam logic [6:0] II  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7 = 1'b0, Zero = 1'b0, Sign = 1'b0, MemReady = 1'b0;
    logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, FaultCode;
    logic [2:0]  ALUControl;
    logic [3:0]  InstRet;
    logic        Fault;

    // Second instance: jal unsupported, always ready, and fed a jal permanently.
    logic        q_req, q_we, q_adr, q_irw, q_pcw, q_rw, q_flt;
    logic [1:0]  q_asa, q_asb, q_rs, q_imm, q_fc;
    logic [2:0]  q_alu;
    logic [31:0] q_ir;

    int checks = 0;
    int failures = 0;
    logic last_pcw = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.TIMEOUT(TO), .CNT_W(4), .SUPPORT_JAL(1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .Sign(Sign), .MemReady(MemReady), .MemReq(MemReq),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .InstRet(InstRet), .Fault(Fault), .FaultCode(FaultCode)
    );

    multicycle_control_unit #(.SUPPORT_JAL(0)) dut_nojal (
        .clk(clk), .rst_n(rst_n), .op(JAL), .funct3(3'b000), .funct7(1'b0),
        .Zero(1'b0), .Sign(1'b0), .MemReady(1'b1), .MemReq(q_req),
        .MemWrite(q_we), .AdrSrc(q_adr), .IRWrite(q_irw), .PCWrite(q_pcw),
        .RegWrite(q_rw), .ALUSrcA(q_asa), .ALUSrcB(q_asb),
        .ResultSrc(q_rs), .ImmSrc(q_imm), .ALUControl(q_alu),
        .InstRet(q_ir), .Fault(q_flt), .FaultCode(q_fc)
    );

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, s, mr;
        logic       req, we, adr, irw, pcw, rw;
        logic [1:0] asa, asb, rsrc, imm;
        logic [2:0] alu;
        logic [3:0] ir;
        logic       flt;
        logic [1:0] fc;
        logic       is_br;
    } rec_t;

    rec_t exp_q[$];

    // Model state: the current instruction fields plus architectural counters.
    logic [6:0] cur_op = '0;
    logic [2:0] cur_f3 = '0;
    logic       cur_f7 = 1'b0, cur_z = 1'b0, cur_s = 1'b0;
    logic [3:0] m_ir = '0;
    logic       m_flt = 1'b0;
    logic [1:0] m_fc = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic rec_t base();
        rec_t r;
        r       = '0;
        r.op    = cur_op;
        r.f3    = cur_f3;
        r.f7    = cur_f7;
        r.z     = cur_z;
        r.s     = cur_s;
        r.mr    = 1'($urandom);
        r.ir    = m_ir;
        r.flt   = m_flt;
        r.fc    = m_fc;
        return r;
    endfunction

    function automatic logic [2:0] alu_exp();
        case (cur_f3)
            3'd0:    return (cur_op == RR && cur_f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic br_taken();
        case (cur_f3)
            3'd0:    return cur_z;
            3'd1:    return !cur_z;
            3'd4:    return cur_s;
            3'd5:    return !cur_s;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_fault(input logic [1:0] code);
        m_flt = 1'b1;
        m_fc  = code;
        for (int i = 0; i < 3; i++) exp_q.push_back(base());
    endtask

    // kind: 0 = instruction fetch, 1 = data read, 2 = data write
    function automatic rec_t mem_rec(input int kind);
        rec_t r;
        r     = base();
        r.req = 1'b1;
        if (kind == 0) begin
            r.asb  = 2'd2;
            r.rsrc = 2'd2;
        end else begin
            r.adr = 1'b1;
            r.we  = (kind == 2);
        end
        return r;
    endfunction

    task automatic p_mem(input int kind, input int stalls, output bit faulted);
        rec_t r;
        faulted = 1'b0;
        for (int i = 0; i < stalls && i < TO; i++) begin
            r = mem_rec(kind);
            r.mr = 1'b0;
            exp_q.push_back(r);
        end
        if (stalls >= TO) begin
            push_fault(2'b10);
            faulted = 1'b1;
        end else begin
            r = mem_rec(kind);
            r.mr = 1'b1;
            if (kind == 0) begin
                r.irw = 1'b1;
                r.pcw = 1'b1;
            end
            exp_q.push_back(r);
            if (kind == 2) m_ir = m_ir + 4'd1;
        end
    endtask

    task automatic aluwb();
        rec_t r;
        r    = base();
        r.rw = 1'b1;
        exp_q.push_back(r);
        m_ir = m_ir + 4'd1;
    endtask

    task automatic gen_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input logic s, input int fs, input int ms);
        rec_t r;
        bit   flt;
        cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_s = s;
        p_mem(0, fs, flt);
        if (!flt) begin
            r = base(); r.asa = 2'd1; r.asb = 2'd1; r.imm = 2'd2;
            exp_q.push_back(r);
            case (o)
                LD, ST: begin
                    r = base(); r.asa = 2'd2; r.asb = 2'd1; r.imm = (o == ST) ? 2'd1 : 2'd0;
                    exp_q.push_back(r);
                    if (o == ST) begin
                        p_mem(2, ms, flt);
                    end else begin
                        p_mem(1, ms, flt);
                        if (!flt) begin
                            r = base(); r.rsrc = 2'd1; r.rw = 1'b1;
                            exp_q.push_back(r);
                            m_ir = m_ir + 4'd1;
                        end
                    end
                end
                RR, II: begin
                    r = base(); r.asa = 2'd2; r.asb = (o == II) ? 2'd1 : 2'd0; r.alu = alu_exp();
                    exp_q.push_back(r);
                    aluwb();
                end
                BR: begin
                    r = base(); r.asa = 2'd2; r.alu = 3'b001; r.pcw = br_taken(); r.is_br = 1'b1;
                    exp_q.push_back(r);
                    m_ir = m_ir + 4'd1;
                end
                JAL: begin
                    r = base(); r.asa = 2'd1; r.asb = 2'd2; r.imm = 2'd3; r.pcw = 1'b1;
                    exp_q.push_back(r);
                    aluwb();
                end
                default: push_fault(2'b01);
            endcase
        end
    endtask

    // Single compare point: drive each cycle's inputs at the falling edge,
    // then check every output against the expected record.
    task automatic run_q();
        rec_t r;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            op = r.op; funct3 = r.f3; funct7 = r.f7; Zero = r.z; Sign = r.s; MemReady = r.mr;
            #1;
            chk("MemReq", 32'(MemReq), 32'(r.req));
            chk("MemWrite", 32'(MemWrite), 32'(r.we));
            chk("AdrSrc", 32'(AdrSrc), 32'(r.adr));
            chk("IRWrite", 32'(IRWrite), 32'(r.irw));
            chk("PCWrite", 32'(PCWrite), 32'(r.pcw));
            chk("RegWrite", 32'(RegWrite), 32'(r.rw));
            chk("ALUSrcA", 32'(ALUSrcA), 32'(r.asa));
            chk("ALUSrcB", 32'(ALUSrcB), 32'(r.asb));
            chk("ResultSrc", 32'(ResultSrc), 32'(r.rsrc));
            chk("ImmSrc", 32'(ImmSrc), 32'(r.imm));
            chk("ALUControl", 32'(ALUControl), 32'(r.alu));
            chk("InstRet", 32'(InstRet), 32'(r.ir));
            chk("Fault", 32'(Fault), 32'(r.flt));
            chk("FaultCode", 32'(FaultCode), 32'(r.fc));
            if (r.is_br) last_pcw = PCWrite;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        rec_t r;
        rst_n = 1'b0;
        #1;
        chk("rst_MemReq", 32'(MemReq), 32'd0);
        chk("rst_InstRet", 32'(InstRet), 32'd0);
        chk("rst_Fault", 32'(Fault), 32'd0);
        chk("rst_FaultCode", 32'(FaultCode), 32'd0);
        chk("rst_nojal_Fault", 32'(q_flt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ir = '0; m_flt = 1'b0; m_fc = '0;
        r = base();
        exp_q.push_back(r);
    endtask

    function automatic logic is_legal(input logic [6:0] o);
        return (o == LD) || (o == ST) || (o == RR) || (o == II) || (o == BR) || (o == JAL);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rec_t r;
        bit   f;
        logic [6:0] rop;
        int   k, fs, ms;

        @(negedge clk);
        apply_reset();

        // add x3,x1,x2 with no stalls
        gen_instr(RR, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_q();
        chk("add_instret", 32'(InstRet), 32'd1);
        chk("nojal_fault", 32'(q_flt), 32'd1);
        chk("nojal_code", 32'(q_fc), 32'd1);
        chk("nojal_instret", q_ir, 32'd0);

        // lw with three stalled cycles in MEMREAD
        gen_instr(LD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
        run_q();
        chk("lw_instret", 32'(InstRet), 32'd2);
        chk("lw_nofault", 32'(Fault), 32'd0);

        gen_instr(BR, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0);
        run_q();
        chk("beq_taken", 32'(last_pcw), 32'd1);
        gen_instr(BR, 3'd1, 1'b0, 1'b1, 1'b0, 0, 0);
        run_q();
        chk("bne_not_taken", 32'(last_pcw), 32'd0);
        gen_instr(BR, 3'd4, 1'b0, 1'b0, 1'b1, 0, 0);
        run_q();
        chk("blt_taken", 32'(last_pcw), 32'd1);
        gen_instr(BR, 3'd2, 1'b0, 1'b1, 1'b1, 0, 0);
        run_q();
        chk("f3_010_not_taken", 32'(last_pcw), 32'd0);
        chk("branch_instret", 32'(InstRet), 32'd6);

        gen_instr(JAL, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        gen_instr(RR, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
        gen_instr(II, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
        // MemReady on the last allowed fetch cycle completes the fetch
        gen_instr(RR, 3'd7, 1'b0, 1'b0, 1'b0, 3, 0);
        run_q();
        chk("late_ready_nofault", 32'(Fault), 32'd0);
        chk("late_ready_instret", 32'(InstRet), 32'd10);

        // sixteen retirements wrap a 4-bit counter back to zero
        apply_reset();
        for (int i = 0; i < 16; i++) gen_instr(II, 3'd6, 1'b0, 1'b0, 1'b0, 0, 0);
        run_q();
        chk("wrap_instret", 32'(InstRet), 32'd0);

        // fetch timeout
        gen_instr(RR, 3'd0, 1'b0, 1'b0, 1'b0, TO, 0);
        run_q();
        chk("timeout_fault", 32'(Fault), 32'd1);
        chk("timeout_code", 32'(FaultCode), 32'd2);
        apply_reset();

        // illegal opcode
        gen_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_q();
        chk("illegal_code", 32'(FaultCode), 32'd1);
        chk("illegal_memreq", 32'(MemReq), 32'd0);
        apply_reset();

        // reset asserted while a store waits for MemReady
        cur_op = ST; cur_f3 = 3'd2; cur_f7 = 1'b0; cur_z = 1'b0; cur_s = 1'b0;
        p_mem(0, 0, f);
        r = base(); r.asa = 2'd1; r.asb = 2'd1; r.imm = 2'd2; exp_q.push_back(r);
        r = base(); r.asa = 2'd2; r.asb = 2'd1; r.imm = 2'd1; exp_q.push_back(r);
        r = mem_rec(2); r.mr = 1'b0; exp_q.push_back(r);
        run_q();
        MemReady = 1'b0;
        #1;
        chk("mw_req_before_reset", 32'(MemReq), 32'd1);
        #1;
        apply_reset();

        // random instruction stream
        for (int n = 0; n < 300; n++) begin
            k  = int'($urandom_range(0, 19));
            fs = ($urandom_range(0, 29) == 0) ? TO : int'($urandom_range(0, 3));
            ms = ($urandom_range(0, 29) == 0) ? TO : int'($urandom_range(0, 3));
            if (k < 4)       rop = LD;
            else if (k < 7)  rop = ST;
            else if (k < 11) rop = RR;
            else if (k < 15) rop = II;
            else if (k < 18) rop = BR;
            else if (k < 19) rop = JAL;
            else begin
                rop = 7'($urandom);
                while (is_legal(rop)) rop = 7'($urandom);
            end
            gen_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), fs, ms);
            run_q();
            if (m_flt) apply_reset();
        end
        run_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
